// File: rtl/escalonador_pkg.sv
// Shared types for the pet activity scheduler: activity codes, attribute ceiling
// and the button request index, whose numeric order is also its priority order.
package escalonador_pkg;

    typedef enum logic [3:0] {
        OCIOSO     = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    localparam int ATRIB_MAX = 100;
    localparam int NUM_REQ   = 3;

    // Lower index wins: dormir > comer > aula.
    typedef enum logic [1:0] {
        REQ_DORMIR = 2'd0,
        REQ_COMER  = 2'd1,
        REQ_AULA   = 2'd2
    } req_t;

    function automatic estado_t req_para_estado(input req_t r);
        case (r)
            REQ_DORMIR: return DORMINDO;
            REQ_COMER:  return COMENDO;
            default:    return DANDO_AULA;
        endcase
    endfunction

    function automatic req_t estado_para_req(input estado_t e);
        case (e)
            DORMINDO: return REQ_DORMIR;
            COMENDO:  return REQ_COMER;
            default:  return REQ_AULA;
        endcase
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Single-bit rising-edge detector: pulses while the input is high and was low
// at the previous clock edge.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic borda
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= din;
    end

    assign borda = din & ~prev;

endmodule

// File: rtl/escalonador_atividades.sv
// Activity scheduler for the pet: arbitrates button requests, times each activity
// in prescaled ticks, applies cooldown and a one-entry pending slot, and latches MORTO.
// Optional forced sleep on low sono is enabled by defining ESCALONADOR_AUTO_DORMIR_EN.
module escalonador_atividades
    import escalonador_pkg::*;
#(
    parameter int TICK_DIV    = 256,
    parameter int DUR_MIN     = 4,
    parameter int DUR_MAX     = 16,
    parameter int COOLDOWN    = 2,
    parameter int LIMIAR_SONO = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_dormir,
    input  logic       btn_comer,
    input  logic       btn_aula,
    input  logic [7:0] fome,
    input  logic [7:0] sono,
    input  logic [7:0] felicidade,
    input  logic       morreu,
    output logic [3:0] estado,
    output logic       ocupado,
    output logic       recusado
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DUR_MAX + 1);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [PW-1:0] PRESC_FIM   = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DUR_MIN_L   = DW'(DUR_MIN);
    localparam logic [DW-1:0] DUR_MAX_L   = DW'(DUR_MAX);
    localparam logic [CW-1:0] CD_INI      = CW'(COOLDOWN);
    localparam logic [7:0]    ATRIB_CHEIO = 8'(ATRIB_MAX);
    localparam logic [7:0]    LIMIAR_L    = 8'(LIMIAR_SONO);

`ifdef ESCALONADOR_AUTO_DORMIR_EN
    localparam bit AUTO_DORMIR = 1'b1;
`else
    localparam bit AUTO_DORMIR = 1'b0;
`endif

    logic [NUM_REQ-1:0] btn, borda;
    logic               best_vld, multi, tick, atrib_cheio, sono_baixo;
    req_t               best_idx;

    estado_t            estado_q, estado_nx;
    logic [DW-1:0]      dur_q, dur_nx, dur_inc;
    logic [CW-1:0]      cd_q, cd_nx;
    logic               pend_vld_q, pend_vld_nx;
    req_t               pend_q, pend_nx;
    logic               rec_q, rec_nx;
    logic [PW-1:0]      presc_q;

    logic               pedido, ativo_vld;
    req_t               ativo_idx;

    assign btn = {btn_aula, btn_comer, btn_dormir};

    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_borda
            detector_borda u_borda (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (btn[i]),
                .borda (borda[i])
            );
        end
    endgenerate

    // Free-running prescaler; activities start at arbitrary phase within a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    assign tick = (presc_q == PRESC_FIM);

    always_comb begin
        best_idx = REQ_AULA;
        if (borda[REQ_DORMIR])     best_idx = REQ_DORMIR;
        else if (borda[REQ_COMER]) best_idx = REQ_COMER;
    end

    assign best_vld = |borda;
    assign multi    = (borda[0] & borda[1]) | (borda[0] & borda[2]) | (borda[1] & borda[2]);

    always_comb begin
        case (estado_q)
            DORMINDO:   atrib_cheio = (sono >= ATRIB_CHEIO);
            COMENDO:    atrib_cheio = (fome >= ATRIB_CHEIO);
            DANDO_AULA: atrib_cheio = (felicidade >= ATRIB_CHEIO);
            default:    atrib_cheio = 1'b0;
        endcase
    end

    assign sono_baixo = AUTO_DORMIR && (sono <= LIMIAR_L);
    assign dur_inc    = (dur_q == DUR_MAX_L) ? dur_q : dur_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            dur_q      <= '0;
            cd_q       <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= REQ_DORMIR;
            rec_q      <= 1'b0;
        end else begin
            estado_q   <= estado_nx;
            dur_q      <= dur_nx;
            cd_q       <= cd_nx;
            pend_vld_q <= pend_vld_nx;
            pend_q     <= pend_nx;
            rec_q      <= rec_nx;
        end
    end

    always_comb begin
        estado_nx   = estado_q;
        dur_nx      = dur_q;
        cd_nx       = cd_q;
        pend_vld_nx = pend_vld_q;
        pend_nx     = pend_q;
        rec_nx      = 1'b0;
        pedido      = 1'b0;
        ativo_vld   = 1'b0;
        ativo_idx   = REQ_DORMIR;

        if (morreu || estado_q == MORTO) begin
            estado_nx   = MORTO;
            dur_nx      = '0;
            cd_nx       = '0;
            pend_vld_nx = 1'b0;
        end else begin
            rec_nx = multi;
            if (estado_q == OCIOSO) begin
                if (tick && cd_q != '0) cd_nx = cd_q - 1'b1;
                if (cd_q != '0) begin
                    pedido = best_vld;
                end else if (sono_baixo) begin
                    estado_nx = DORMINDO;
                    dur_nx    = '0;
                    rec_nx    = best_vld;
                end else if (pend_vld_q) begin
                    // Slot empties as its activity starts, so a fresh edge may refill it.
                    estado_nx   = req_para_estado(pend_q);
                    dur_nx      = '0;
                    pend_vld_nx = 1'b0;
                    pedido      = best_vld;
                    ativo_vld   = 1'b1;
                    ativo_idx   = pend_q;
                end else if (best_vld) begin
                    estado_nx = req_para_estado(best_idx);
                    dur_nx    = '0;
                end
            end else begin
                pedido    = best_vld;
                ativo_vld = 1'b1;
                ativo_idx = estado_para_req(estado_q);
                if (tick) begin
                    dur_nx = dur_inc;
                    if (dur_inc == DUR_MAX_L || (dur_inc >= DUR_MIN_L && atrib_cheio)) begin
                        estado_nx = OCIOSO;
                        dur_nx    = '0;
                        cd_nx     = CD_INI;
                    end
                end
            end

            if (pedido) begin
                if (ativo_vld && best_idx == ativo_idx) begin
                    rec_nx = 1'b1;
                end else if (!pend_vld_nx || best_idx < pend_nx) begin
                    pend_vld_nx = 1'b1;
                    pend_nx     = best_idx;
                end else begin
                    rec_nx = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (estado_q)
            DORMINDO, COMENDO, DANDO_AULA: ocupado = 1'b1;
            OCIOSO:                        ocupado = (cd_q != '0);
            default:                       ocupado = 1'b0;
        endcase
    end

    assign estado   = estado_q;
    assign recusado = rec_q;

endmodule

// File: tb/tb_escalonador_atividades.sv
// Self-checking bench for escalonador_atividades: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_escalonador_atividades;

    localparam int TICK_DIV    = 4;
    localparam int DUR_MIN     = 2;
    localparam int DUR_MAX     = 5;
    localparam int COOLDOWN    = 1;
    localparam int LIMIAR_SONO = 20;
    localparam int IDLE = -1;
    localparam int DEAD = 3;
`ifdef ESCALONADOR_AUTO_DORMIR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_dormir, btn_comer, btn_aula, morreu;
    logic [7:0] fome, sono, felicidade;
    logic [3:0] estado;
    logic       ocupado, recusado;

    int checks   = 0;
    int failures = 0;

    escalonador_atividades #(
        .TICK_DIV    (TICK_DIV),
        .DUR_MIN     (DUR_MIN),
        .DUR_MAX     (DUR_MAX),
        .COOLDOWN    (COOLDOWN),
        .LIMIAR_SONO (LIMIAR_SONO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_dormir (btn_dormir),
        .btn_comer  (btn_comer),
        .btn_aula   (btn_aula),
        .fome       (fome),
        .sono       (sono),
        .felicidade (felicidade),
        .morreu     (morreu),
        .estado     (estado),
        .ocupado    (ocupado),
        .recusado   (recusado)
    );

    always #5 clk = ~clk;

    // Reference model: activity index (-1 idle, 0 dormir, 1 comer, 2 aula, 3 dead)
    int       m_act, m_dur, m_cd, m_edges;
    int       m_pend[$];
    bit [2:0] m_prev;
    bit       m_rec;

    function automatic logic [3:0] est_code(input int a);
        case (a)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0100;
            DEAD:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit model_oc();
        return (m_act >= 0 && m_act <= 2) || (m_act == IDLE && m_cd > 0);
    endfunction

    task automatic model_reset();
        m_act = IDLE; m_dur = 0; m_cd = 0; m_edges = 0; m_prev = '0; m_rec = 1'b0;
        m_pend.delete();
    endtask

    task automatic offer(input int ed[$], input int run);
        if (ed.size() == 0) return;
        if (ed.size() > 1) m_rec = 1'b1;
        if (ed[0] == run) m_rec = 1'b1;
        else if (m_pend.size() == 0 || ed[0] < m_pend[0]) begin
            m_pend.delete();
            m_pend.push_back(ed[0]);
        end else m_rec = 1'b1;
    endtask

    task automatic model_step(input bit d, input bit c, input bit a, input bit m,
                              input int f, input int s, input int h);
        bit [2:0] b, e;
        int       ed[$];
        bit       tk;
        int       cd0, at;
        b = {a, c, d};
        e = b & ~m_prev;
        m_prev = b;
        for (int i = 0; i < 3; i++) if (e[i]) ed.push_back(i);
        tk = (m_edges % TICK_DIV) == TICK_DIV - 1;
        m_edges++;
        m_rec = 1'b0;
        if (m || m_act == DEAD) begin
            m_act = DEAD; m_cd = 0; m_pend.delete();
        end else if (m_act == IDLE) begin
            cd0 = m_cd;
            if (tk && m_cd > 0) m_cd--;
            if (cd0 > 0) offer(ed, IDLE);
            else if (AUTO && s <= LIMIAR_SONO) begin
                m_act = 0; m_dur = 0; m_rec = (ed.size() > 0);
            end else if (m_pend.size() > 0) begin
                m_act = m_pend[0]; m_pend.delete(); m_dur = 0;
                offer(ed, m_act);
            end else if (ed.size() > 0) begin
                m_act = ed[0]; m_dur = 0; m_rec = (ed.size() > 1);
            end
        end else begin
            offer(ed, m_act);
            if (tk) begin
                m_dur = (m_dur < DUR_MAX) ? m_dur + 1 : DUR_MAX;
                at = (m_act == 0) ? s : (m_act == 1) ? f : h;
                if (m_dur == DUR_MAX || (m_dur >= DUR_MIN && at >= 100)) begin
                    m_act = IDLE; m_cd = COOLDOWN;
                end
            end
        end
    endtask

    task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Entered just after a negedge; returns just after the following negedge.
    task automatic step(input bit d, input bit c, input bit a, input bit m,
                        input int f, input int s, input int h);
        btn_dormir = d; btn_comer = c; btn_aula = a; morreu = m;
        fome = f[7:0]; sono = s[7:0]; felicidade = h[7:0];
        model_step(d, c, a, m, f, s, h);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_dormir = 0; btn_comer = 0; btn_aula = 0; morreu = 0;
        #1;
        chk("reset estado", {4'b0, estado}, 8'h00);
        chk("reset ocupado", {7'b0, ocupado}, 8'h00);
        chk("reset recusado", {7'b0, recusado}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         reps;
        bit         d, c, a;
        int         fome, sono;
        logic [3:0] est;
        bit         rec, oc;
    } vec_t;

    vec_t vt[10];

    initial begin
        int f, s, h;
        rst_n = 1'b0;
        btn_dormir = 0; btn_comer = 0; btn_aula = 0; morreu = 0;
        fome = 8'd50; sono = 8'd50; felicidade = 8'd50;

        // Rows cover edges 0..35 after reset; ticks fall on edges 3, 7, 11, ...
        vt[0] = '{1,  0, 1, 0, 50, 50,  4'b0010, 1'b0, 1'b1};
        vt[1] = '{18, 0, 0, 0, 50, 50,  4'b0010, 1'b0, 1'b1};
        vt[2] = '{4,  0, 0, 0, 50, 50,  4'b0000, 1'b0, 1'b1};
        vt[3] = '{2,  0, 0, 0, 50, 50,  4'b0000, 1'b0, 1'b0};
        vt[4] = '{1,  1, 0, 1, 50, 50,  4'b0001, 1'b1, 1'b1};
        vt[5] = '{2,  0, 0, 0, 50, 50,  4'b0001, 1'b0, 1'b1};
        vt[6] = '{3,  0, 0, 0, 50, 100, 4'b0001, 1'b0, 1'b1};
        vt[7] = '{1,  0, 0, 0, 50, 100, 4'b0000, 1'b0, 1'b1};
        vt[8] = '{3,  0, 0, 0, 50, 50,  4'b0000, 1'b0, 1'b1};
        vt[9] = '{1,  0, 0, 0, 50, 50,  4'b0000, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < vt[r].reps; k++) begin
                step(vt[r].d, vt[r].c, vt[r].a, 1'b0, vt[r].fome, vt[r].sono, 50);
                chk($sformatf("vec%0d.%0d estado", r, k), {4'b0, estado}, {4'b0, vt[r].est});
                chk($sformatf("vec%0d.%0d recusado", r, k), {7'b0, recusado}, {7'b0, vt[r].rec});
                chk($sformatf("vec%0d.%0d ocupado", r, k), {7'b0, ocupado}, {7'b0, vt[r].oc});
            end
        end

        // Pending request started after cooldown, then death and async reset.
        do_reset();
        step(0, 1, 0, 0, 50, 50, 50);
        chk("pend comer entra", {4'b0, estado}, 8'h02);
        step(0, 0, 1, 0, 50, 50, 50);
        chk("pend aula guardada", {4'b0, estado}, 8'h02);
        chk("pend aula sem recusa", {7'b0, recusado}, 8'h00);
        repeat (17) step(0, 0, 0, 0, 50, 50, 50);
        chk("pend comer ainda", {4'b0, estado}, 8'h02);
        step(0, 0, 0, 0, 50, 50, 50);
        chk("pend comer fim", {4'b0, estado}, 8'h00);
        chk("pend cooldown ocupado", {7'b0, ocupado}, 8'h01);
        repeat (4) step(0, 0, 0, 0, 50, 50, 50);
        chk("pend cooldown zerado", {7'b0, ocupado}, 8'h00);
        step(0, 0, 0, 0, 50, 50, 50);
        chk("pend aula inicia", {4'b0, estado}, 8'h04);
        step(0, 0, 0, 1, 50, 50, 50);
        chk("morto entra", {4'b0, estado}, 8'h08);
        chk("morto ocupado", {7'b0, ocupado}, 8'h00);
        step(1, 0, 0, 0, 50, 50, 50);
        chk("morto dormir", {4'b0, estado}, 8'h08);
        chk("morto dormir recusado", {7'b0, recusado}, 8'h00);
        step(0, 1, 1, 0, 50, 50, 50);
        chk("morto comer aula", {4'b0, estado}, 8'h08);
        chk("morto comer recusado", {7'b0, recusado}, 8'h00);
        do_reset();

        // Low sono while idle with a teach request.
        step(0, 0, 1, 0, 50, 15, 50);
`ifdef ESCALONADOR_AUTO_DORMIR_EN
        chk("auto dormir estado", {4'b0, estado}, 8'h01);
        chk("auto dormir recusado", {7'b0, recusado}, 8'h01);
`else
        chk("sem auto estado", {4'b0, estado}, 8'h04);
        chk("sem auto recusado", {7'b0, recusado}, 8'h00);
`endif
        step(0, 0, 0, 0, 50, 50, 50);
        do_reset();

        // Randomized traffic against the model.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int n = 0; n < 600; n++) begin
                f = ($urandom_range(0, 3) == 0) ? 100 : int'($urandom_range(0, 99));
                case ($urandom_range(0, 5))
                    0:       s = 100;
                    1:       s = int'($urandom_range(0, 25));
                    default: s = int'($urandom_range(30, 99));
                endcase
                h = ($urandom_range(0, 3) == 0) ? 100 : int'($urandom_range(0, 99));
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 399) == 0), f, s, h);
                chk("rnd estado", {4'b0, estado}, {4'b0, est_code(m_act)});
                chk("rnd recusado", {7'b0, recusado}, {7'b0, m_rec});
                chk("rnd ocupado", {7'b0, ocupado}, {7'b0, model_oc()});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
